// File: rtl/mem_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mem_arbiter_pkg
// Shared definitions for the byte-wide RAM arbiter: FSM state encodings,
// owner codes, enable/zero constants, the latched-request record and the
// byte-lane helpers used to serialise and reassemble 32-bit words.
// Byte lane numbering: lane k (0..3) is byte offset k, which lives in
// word[31-8k -: 8], so lane 0 is the most significant byte.
// ---------------------------------------------------------------------------
package mem_arbiter_pkg;

   localparam int RAM_AW_DEFAULT = 17;

   // FSM state encodings
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_XFER = 2'd1;
   localparam logic [1:0] ST_TAIL = 2'd2;
   localparam logic [1:0] ST_ACK  = 2'd3;

   // Owner of the transfer in flight
   localparam logic OWNER_IF  = 1'b0;
   localparam logic OWNER_MEM = 1'b1;

   localparam logic        CHIP_ENABLE  = 1'b1;
   localparam logic        WRITE_ENABLE = 1'b1;
   localparam logic [31:0] ZERO_WORD    = 32'h0000_0000;

   // Everything about a granted access that must survive operand changes
   typedef struct packed {
      logic        owner;
      logic        we;
      logic [3:0]  sel;
      logic [31:0] wdata;
   } xfer_req_t;

   // Extract byte lane k of a word
   function automatic logic [7:0] get_byte(input logic [31:0] word, input logic [1:0] k);
      logic [7:0] b;
      case (k)
         2'd0:    b = word[31:24];
         2'd1:    b = word[23:16];
         2'd2:    b = word[15:8];
         default: b = word[7:0];
      endcase
      return b;
   endfunction

   // Replace byte lane k of a word
   function automatic logic [31:0] put_byte(input logic [31:0] word, input logic [1:0] k,
                                            input logic [7:0] b);
      logic [31:0] w;
      w = word;
      case (k)
         2'd0:    w[31:24] = b;
         2'd1:    w[23:16] = b;
         2'd2:    w[15:8]  = b;
         default: w[7:0]   = b;
      endcase
      return w;
   endfunction

endpackage

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
// Shares one byte-wide RAM port between the instruction-fetch requester (IF)
// and the data-memory requester (MEM). MEM has fixed priority. A granted
// 32-bit access is latched and serialised into four byte cycles; read bytes
// are reassembled and returned with a one-cycle acknowledge.
//
// Ports:
//   clk, rst          clock / asynchronous active-low reset
//   if_req/if_addr    IF word-read request (held until if_ack)
//   if_ack/if_rdata   IF one-cycle acknowledge and fetched word
//   mem_req/we/addr/sel/wdata   MEM request, held until mem_ack
//   mem_ack/mem_rdata MEM one-cycle acknowledge and read word
//   ram_addr/ce/we/dout/din     byte-wide RAM port (din one cycle after addr)
//   stallreq_if/mem   pipeline stall requests while a requester waits
// ---------------------------------------------------------------------------
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int RAM_AW = RAM_AW_DEFAULT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [31:0]       if_addr,
   output logic              if_ack,
   output logic [31:0]       if_rdata,
   input  logic              mem_req,
   input  logic              mem_we,
   input  logic [31:0]       mem_addr,
   input  logic [3:0]        mem_sel,
   input  logic [31:0]       mem_wdata,
   output logic              mem_ack,
   output logic [31:0]       mem_rdata,
   output logic [RAM_AW-1:0] ram_addr,
   output logic              ram_ce,
   output logic              ram_we,
   output logic [7:0]        ram_dout,
   input  logic [7:0]        ram_din,
   output logic              stallreq_if,
   output logic              stallreq_mem
);

   logic [1:0]        state;
   logic [1:0]        k;
   xfer_req_t         req_q;
   logic [RAM_AW-1:0] base;
   logic [31:0]       rdata_acc;

   logic [1:0]        cap_k;
   logic [7:0]        cap_byte;
   logic              cur_sel;

   // Address bits outside the RAM window and the word offset are ignored
   logic unused_addr_bits;
   assign unused_addr_bits = &{1'b0, if_addr[31:RAM_AW], if_addr[1:0],
                               mem_addr[31:RAM_AW], mem_addr[1:0]};

   assign cur_sel = req_q.sel[2'd3 - k];

   // RAM port is driven only while a byte is being transferred; in every
   // other state (including reset) all RAM outputs are zero.
   always_comb begin
      ram_addr = '0;
      ram_ce   = 1'b0;
      ram_we   = 1'b0;
      ram_dout = 8'h00;
      if (state == ST_XFER) begin
         ram_addr = base + {{(RAM_AW-2){1'b0}}, k};
         ram_ce   = cur_sel & CHIP_ENABLE;
         ram_we   = req_q.we & cur_sel & WRITE_ENABLE;
         ram_dout = get_byte(req_q.wdata, k);
      end
   end

   // The byte on ram_din belongs to the lane addressed one cycle earlier:
   // lane k-1 while in XFER, lane 3 in TAIL. Unselected lanes read as 0.
   always_comb begin
      cap_k    = (state == ST_TAIL) ? 2'd3 : (k - 2'd1);
      cap_byte = req_q.sel[2'd3 - cap_k] ? ram_din : 8'h00;
   end

   assign if_ack       = (state == ST_ACK) && (req_q.owner == OWNER_IF);
   assign mem_ack      = (state == ST_ACK) && (req_q.owner == OWNER_MEM);
   assign stallreq_if  = if_req & ~if_ack;
   assign stallreq_mem = mem_req & ~mem_ack;

   // Arbitration and byte sequencing. The owner's rdata register is loaded
   // when the last byte lands, so it is valid during ACK and then simply
   // holds; the other requester's rdata is never touched.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= ST_IDLE;
         k         <= 2'd0;
         req_q     <= '0;
         base      <= '0;
         rdata_acc <= ZERO_WORD;
         if_rdata  <= ZERO_WORD;
         mem_rdata <= ZERO_WORD;
      end else begin
         case (state)
            ST_IDLE: begin
               k         <= 2'd0;
               rdata_acc <= ZERO_WORD;
               if (mem_req) begin
                  req_q <= '{owner: OWNER_MEM, we: mem_we, sel: mem_sel, wdata: mem_wdata};
                  base  <= {mem_addr[RAM_AW-1:2], 2'b00};
                  state <= ST_XFER;
               end else if (if_req) begin
                  req_q <= '{owner: OWNER_IF, we: 1'b0, sel: 4'b1111, wdata: ZERO_WORD};
                  base  <= {if_addr[RAM_AW-1:2], 2'b00};
                  state <= ST_XFER;
               end
            end
            ST_XFER: begin
               if (k != 2'd0) begin
                  rdata_acc <= put_byte(rdata_acc, cap_k, cap_byte);
               end
               if (k == 2'd3) begin
                  state <= req_q.we ? ST_ACK : ST_TAIL;
               end else begin
                  k <= k + 2'd1;
               end
            end
            ST_TAIL: begin
               if (req_q.owner == OWNER_MEM) begin
                  mem_rdata <= put_byte(rdata_acc, cap_k, cap_byte);
               end else begin
                  if_rdata <= put_byte(rdata_acc, cap_k, cap_byte);
               end
               state <= ST_ACK;
            end
            default: begin
               k     <= 2'd0;
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
// Directed bench for mem_arbiter with a behavioural byte RAM (registered
// read, one cycle latency). Cycle C0 is the cycle in which a request is
// first presented; outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

   localparam int RAM_AW = 17;

   logic              clk;
   logic              rst;
   logic              if_req;
   logic [31:0]       if_addr;
   logic              if_ack;
   logic [31:0]       if_rdata;
   logic              mem_req;
   logic              mem_we;
   logic [31:0]       mem_addr;
   logic [3:0]        mem_sel;
   logic [31:0]       mem_wdata;
   logic              mem_ack;
   logic [31:0]       mem_rdata;
   logic [RAM_AW-1:0] ram_addr;
   logic              ram_ce;
   logic              ram_we;
   logic [7:0]        ram_dout;
   logic [7:0]        ram_din;
   logic              stallreq_if;
   logic              stallreq_mem;

   mem_arbiter #(.RAM_AW(RAM_AW)) dut (
      .clk          (clk),
      .rst          (rst),
      .if_req       (if_req),
      .if_addr      (if_addr),
      .if_ack       (if_ack),
      .if_rdata     (if_rdata),
      .mem_req      (mem_req),
      .mem_we       (mem_we),
      .mem_addr     (mem_addr),
      .mem_sel      (mem_sel),
      .mem_wdata    (mem_wdata),
      .mem_ack      (mem_ack),
      .mem_rdata    (mem_rdata),
      .ram_addr     (ram_addr),
      .ram_ce       (ram_ce),
      .ram_we       (ram_we),
      .ram_dout     (ram_dout),
      .ram_din      (ram_din),
      .stallreq_if  (stallreq_if),
      .stallreq_mem (stallreq_mem)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural RAM with a backdoor write port for preloading
   logic [7:0]        ram_mem [0:(1<<RAM_AW)-1];
   logic              bd_we;
   logic [RAM_AW-1:0] bd_addr;
   logic [7:0]        bd_data;

   always @(posedge clk) begin
      if (bd_we) ram_mem[bd_addr] <= bd_data;
      else if (ram_ce && ram_we) ram_mem[ram_addr] <= ram_dout;
      ram_din <= ram_mem[ram_addr];
   end

   int err_count;
   int check_count;

   // Per-cycle trace recorded by runCycles
   logic [RAM_AW-1:0] tr_addr [0:31];
   logic              tr_ce   [0:31];
   logic              tr_we   [0:31];
   logic [7:0]        tr_dout [0:31];
   logic              tr_sif  [0:31];
   int                if_ack_cyc, mem_ack_cyc, if_ack_n, mem_ack_n;
   logic [31:0]       if_word, mem_word;

   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      check_count++;
      if (actual !== expected) begin
         err_count++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic ireq, input logic [31:0] iaddr,
                                input logic mreq, input logic mwe,
                                input logic [31:0] maddr, input logic [3:0] msel,
                                input logic [31:0] mwdata);
      if_req    = ireq;
      if_addr   = iaddr;
      mem_req   = mreq;
      mem_we    = mwe;
      mem_addr  = maddr;
      mem_sel   = msel;
      mem_wdata = mwdata;
   endtask

   task automatic ramPoke(input logic [RAM_AW-1:0] a, input logic [7:0] d);
      bd_addr = a;
      bd_data = d;
      bd_we   = 1'b1;
      @(posedge clk);
      #1;
      bd_we   = 1'b0;
   endtask

   function automatic logic [31:0] ramWord(input logic [RAM_AW-1:0] a);
      return {ram_mem[a], ram_mem[a+1], ram_mem[a+2], ram_mem[a+3]};
   endfunction

   // Run n cycles starting at C0, recording the RAM port and acks; a
   // requester drops its request in the cycle after its ack.
   task automatic runCycles(input int n);
      logic drop_if, drop_mem;
      if_ack_cyc  = -1;
      mem_ack_cyc = -1;
      if_ack_n    = 0;
      mem_ack_n   = 0;
      for (int c = 0; c < n; c++) begin
         @(negedge clk);
         tr_addr[c] = ram_addr;
         tr_ce[c]   = ram_ce;
         tr_we[c]   = ram_we;
         tr_dout[c] = ram_dout;
         tr_sif[c]  = stallreq_if;
         drop_if    = 1'b0;
         drop_mem   = 1'b0;
         if (if_ack) begin
            if_ack_n++;
            if_ack_cyc = c;
            if_word    = if_rdata;
            drop_if    = 1'b1;
         end
         if (mem_ack) begin
            mem_ack_n++;
            mem_ack_cyc = c;
            mem_word    = mem_rdata;
            drop_mem    = 1'b1;
         end
         @(posedge clk);
         #1;
         if (drop_if)  if_req  = 1'b0;
         if (drop_mem) mem_req = 1'b0;
      end
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int sif_high;
      err_count   = 0;
      check_count = 0;
      rst         = 1'b0;
      bd_we       = 1'b0;
      bd_addr     = '0;
      bd_data     = 8'h00;
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
      repeat (2) @(posedge clk);
      #1;

      // Reset held with both requests high; preload RAM meanwhile
      applyStimulus(1'b1, 32'h100, 1'b1, 1'b0, 32'h300, 4'b1100, 32'h0);
      ramPoke(17'h00100, 8'h11); ramPoke(17'h00101, 8'h22);
      ramPoke(17'h00102, 8'h33); ramPoke(17'h00103, 8'h44);
      ramPoke(17'h00300, 8'hA1); ramPoke(17'h00301, 8'hB2);
      ramPoke(17'h00302, 8'hC3); ramPoke(17'h00303, 8'hD4);
      ramPoke(17'h00200, 8'h10); ramPoke(17'h00201, 8'h20);
      ramPoke(17'h00202, 8'h30); ramPoke(17'h00203, 8'h40);
      for (int i = 0; i < 4; i++) ramPoke(17'h00400 + 17'(i), 8'hEE);
      ramPoke(17'h1FFFC, 8'hC1); ramPoke(17'h1FFFD, 8'hC2);
      ramPoke(17'h1FFFE, 8'hC3); ramPoke(17'h1FFFF, 8'hC4);
      ramPoke(17'h00000, 8'h5A);

      @(negedge clk);
      checkOutput("reset if_ack",    32'(if_ack),    32'h0);
      checkOutput("reset mem_ack",   32'(mem_ack),   32'h0);
      checkOutput("reset if_rdata",  if_rdata,       32'h0);
      checkOutput("reset mem_rdata", mem_rdata,      32'h0);
      checkOutput("reset ram_addr",  32'(ram_addr),  32'h0);
      checkOutput("reset ram_ce",    32'(ram_ce),    32'h0);
      checkOutput("reset ram_we",    32'(ram_we),    32'h0);
      checkOutput("reset ram_dout",  32'(ram_dout),  32'h0);
      checkOutput("reset stall_if",  32'(stallreq_if),  32'h1);
      checkOutput("reset stall_mem", 32'(stallreq_mem), 32'h1);

      // Release: MEM read (0x300, sel 1100) beats the IF read of 0x100
      @(posedge clk);
      #1;
      rst = 1'b1;
      runCycles(16);
      checkOutput("contend first addr", 32'(tr_addr[1]), 32'h300);
      checkOutput("contend ce lane0",   32'(tr_ce[1]),   32'h1);
      checkOutput("contend ce lane2",   32'(tr_ce[3]),   32'h0);
      checkOutput("contend mem_ack cyc", 32'(mem_ack_cyc), 32'd6);
      checkOutput("contend mem_rdata",  mem_word,        32'hA1B20000);
      checkOutput("contend if_ack cyc", 32'(if_ack_cyc), 32'd13);
      checkOutput("contend if_rdata",   if_word,         32'h11223344);
      sif_high = 0;
      for (int c = 0; c <= 12; c++) if (tr_sif[c]) sif_high++;
      checkOutput("contend stall_if C0-C12", 32'(sif_high), 32'd13);
      checkOutput("contend stall_if C13",    32'(tr_sif[13]), 32'h0);

      // IF read alone
      applyStimulus(1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
      runCycles(10);
      for (int c = 1; c <= 4; c++) begin
         checkOutput($sformatf("ifrd addr C%0d", c), 32'(tr_addr[c]), 32'h100 + 32'(c - 1));
         checkOutput($sformatf("ifrd ce C%0d", c),   32'(tr_ce[c]),   32'h1);
      end
      checkOutput("ifrd we",        32'(tr_we[2]),    32'h0);
      checkOutput("ifrd ack cyc",   32'(if_ack_cyc),  32'd6);
      checkOutput("ifrd ack count", 32'(if_ack_n),    32'd1);
      checkOutput("ifrd no mem_ack", 32'(mem_ack_n),  32'd0);
      checkOutput("ifrd rdata",     if_word,          32'h11223344);

      // MEM single-byte write to offset 2
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h202, 4'b0010, 32'h0000AB00);
      runCycles(8);
      checkOutput("bytewr ce C1",  32'(tr_ce[1]),   32'h0);
      checkOutput("bytewr ce C2",  32'(tr_ce[2]),   32'h0);
      checkOutput("bytewr ce C3",  32'(tr_ce[3]),   32'h1);
      checkOutput("bytewr ce C4",  32'(tr_ce[4]),   32'h0);
      checkOutput("bytewr we C3",  32'(tr_we[3]),   32'h1);
      checkOutput("bytewr we C2",  32'(tr_we[2]),   32'h0);
      checkOutput("bytewr addr C3", 32'(tr_addr[3]), 32'h202);
      checkOutput("bytewr dout C3", 32'(tr_dout[3]), 32'hAB);
      checkOutput("bytewr ack cyc", 32'(mem_ack_cyc), 32'd5);
      checkOutput("bytewr ram word", ramWord(17'h00200), 32'h1020AB40);

      // Contention with a MEM write: IF acks one cycle sooner
      applyStimulus(1'b1, 32'h100, 1'b1, 1'b1, 32'h500, 4'b1111, 32'h01020304);
      runCycles(16);
      checkOutput("contwr mem_ack cyc", 32'(mem_ack_cyc), 32'd5);
      checkOutput("contwr if_ack cyc",  32'(if_ack_cyc),  32'd12);
      checkOutput("contwr if_rdata",    if_word,          32'h11223344);
      checkOutput("contwr ram word",    ramWord(17'h00500), 32'h01020304);

      // Reset asserted during C3 of a full-word write
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h400, 4'b1111, 32'h55667788);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      checkOutput("midrst mem_ack", 32'(mem_ack), 32'h0);
      checkOutput("midrst ram_ce",  32'(ram_ce),  32'h0);
      @(negedge clk);
      checkOutput("midrst mem_ack late", 32'(mem_ack), 32'h0);
      checkOutput("midrst partial word", ramWord(17'h00400), 32'h5566EEEE);
      @(posedge clk);
      #1;
      rst = 1'b1;
      runCycles(8);
      checkOutput("midrst regrant ack cyc", 32'(mem_ack_cyc), 32'd5);
      checkOutput("midrst full word", ramWord(17'h00400), 32'h55667788);

      // Top-of-RAM read and out-of-window MEM address
      applyStimulus(1'b1, 32'h1FFFC, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
      runCycles(10);
      for (int c = 1; c <= 4; c++) begin
         checkOutput($sformatf("wrap addr C%0d", c), 32'(tr_addr[c]), 32'h1FFFC + 32'(c - 1));
      end
      checkOutput("wrap if_rdata", if_word, 32'hC1C2C3C4);
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h20000, 4'b1000, 32'h0);
      runCycles(10);
      checkOutput("wrap mem addr C1", 32'(tr_addr[1]), 32'h0);
      checkOutput("wrap mem ce C1",   32'(tr_ce[1]),   32'h1);
      checkOutput("wrap mem ack cyc", 32'(mem_ack_cyc), 32'd6);
      checkOutput("wrap mem_rdata",   mem_word,         32'h5A000000);
      checkOutput("wrap if_rdata held", if_rdata,       32'hC1C2C3C4);

      $display("Result: errors=%0d of %0d checks", err_count, check_count);
      $finish;
   end

endmodule
